// File: rtl/pulse_emitter_pkg.sv
// pulse_emitter_pkg: shared state encodings and constant helpers for the pulse emitter
package pulse_emitter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_emitter_tick_prescaler.sv
// tick_prescaler: free-running DIV_BITS counter with sync clear, ticks when all ones
module tick_prescaler
    import pulse_emitter_pkg::*;
#(
    parameter int DIV_BITS = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    logic [DIV_BITS-1:0] cnt_q, cnt_d;

    // clear restarts a full tick period so the first tick after a clear is never partial
    always_comb cnt_d = clr ? '0 : cnt_q + DIV_BITS'(1);

    // prescaler count register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/pulse_emitter.sv
// pulse_emitter: turns trig requests into fixed-length output pulses with a minimum gap and a small request queue
module pulse_emitter
    import pulse_emitter_pkg::*;
#(
    parameter int DIV_BITS  = 18,
    parameter int ON_TICKS  = 8,
    parameter int GAP_TICKS = 4,
    parameter int PEND_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    output logic              out_level,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              drop
);

    localparam int              TW       = $clog2(max_int(ON_TICKS, GAP_TICKS) + 1);
    localparam logic [TW-1:0]   ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0]   GAP_LAST = TW'(GAP_TICKS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_e              state_q, state_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                out_q, busy_q, drop_q, drop_d;
    logic                tick, clr, done, queue_trig;

    tick_prescaler #(.DIV_BITS(DIV_BITS)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    // any state change restarts both the prescaler and the tick counter
    assign clr        = state_d != state_q;
    assign done       = tick && (tcnt_q == ((state_q == ON) ? ON_LAST : GAP_LAST));
    assign queue_trig = trig && ((state_q == ON) || ((state_q == GAP) && !done));

    // next-state, queue bookkeeping and drop detection
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                pend_d = '0;
                if (trig) state_d = ON;
            end
            ON: begin
                if (done) state_d = GAP;
            end
            GAP: begin
                if (done) begin
                    if (pend_q != '0) begin
                        state_d = ON;
                        if (!trig) pend_d = pend_q - PEND_W'(1);
                    end else begin
                        state_d = trig ? ON : IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase
        if (queue_trig) begin
            if (pend_q == PEND_MAX) drop_d = 1'b1;
            else                    pend_d = pend_q + PEND_W'(1);
        end
    end

    // ticks elapsed in the current ON or GAP phase
    always_comb tcnt_d = clr ? '0 : tcnt_q + TW'(tick);

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            pend_q  <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            pend_q  <= pend_d;
            out_q   <= state_d == ON;
            busy_q  <= state_d != IDLE;
            drop_q  <= drop_d;
        end
    end

    assign out_level = out_q;
    assign busy      = busy_q;
    assign pend_cnt  = pend_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_pulse_emitter.sv
// tb_pulse_emitter: directed stimulus with a pulse/drop scoreboard for pulse_emitter
module tb_pulse_emitter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trig = 1'b0;
    logic       out_level, busy, drop;
    logic [1:0] pend_cnt;

    int cyc = 0;
    int base = 0;
    int total = 0;
    int bad = 0;
    int exp_start[$];
    int exp_width[$];
    int exp_drop[$];
    int start_c = 0;
    logic prev_out = 1'b0;

    pulse_emitter #(
        .DIV_BITS  (2),
        .ON_TICKS  (3),
        .GAP_TICKS (2),
        .PEND_W    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .trig      (trig),
        .out_level (out_level),
        .busy      (busy),
        .pend_cnt  (pend_cnt),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    // absolute cycle number, never reset
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops expected pulses and drops as the DUT presents them
    always @(posedge clk) begin
        #1;
        if (out_level && !prev_out) start_c = cyc;
        if (!out_level && prev_out) begin
            if (exp_start.size() == 0) check("unexpected_pulse", start_c, -1);
            else begin
                check("pulse_start", start_c, exp_start.pop_front());
                check("pulse_width", cyc - start_c, exp_width.pop_front());
            end
        end
        if (drop) begin
            if (exp_drop.size() == 0) check("unexpected_drop", cyc, -1);
            else check("drop_cycle", cyc, exp_drop.pop_front());
        end
        prev_out = out_level;
    end

    task automatic at(input int c);
        while (cyc < base + c) @(negedge clk);
    endtask

    task automatic trig_at(input int c);
        at(c);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        base = cyc;
    endtask

    task automatic expect_pulse(input int s, input int w);
        exp_start.push_back(base + s);
        exp_width.push_back(w);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // single pulse
        do_reset();
        check("rst_out", out_level, 0);
        check("rst_busy", busy, 0);
        check("rst_pend", pend_cnt, 0);
        check("rst_drop", drop, 0);
        expect_pulse(11, 12);
        trig_at(10);
        at(15); check("t1_pend", pend_cnt, 0); check("t1_busy15", busy, 1);
        at(22); check("t1_out22", out_level, 1);
        at(23); check("t1_out23", out_level, 0); check("t1_busy23", busy, 1);
        at(30); check("t1_busy30", busy, 1);
        at(31); check("t1_busy31", busy, 0);
        at(40);

        // queueing
        do_reset();
        expect_pulse(11, 12); expect_pulse(31, 12); expect_pulse(51, 12); expect_pulse(71, 12);
        trig_at(10); trig_at(13); trig_at(14); trig_at(15);
        at(16); check("t2_pend16", pend_cnt, 3);
        at(31); check("t2_pend31", pend_cnt, 2);
        at(51); check("t2_pend51", pend_cnt, 1);
        at(70); check("t2_pend70", pend_cnt, 1);
        at(71); check("t2_pend71", pend_cnt, 0);
        at(90); check("t2_busy90", busy, 1);
        at(91); check("t2_busy91", busy, 0);
        at(95);

        // saturation
        do_reset();
        expect_pulse(11, 12); expect_pulse(31, 12); expect_pulse(51, 12); expect_pulse(71, 12);
        exp_drop.push_back(base + 18);
        trig_at(10); trig_at(13); trig_at(14); trig_at(15); trig_at(17);
        at(18); check("t3_pend18", pend_cnt, 3); check("t3_drop18", drop, 1);
        at(19); check("t3_pend19", pend_cnt, 3); check("t3_drop19", drop, 0);
        at(91); check("t3_busy91", busy, 0);
        at(95);

        // trig in final GAP cycle, empty queue
        do_reset();
        expect_pulse(11, 12); expect_pulse(31, 12);
        trig_at(10);
        at(30); check("t4a_busy30", busy, 1);
        trig_at(30);
        at(31); check("t4a_busy31", busy, 1); check("t4a_out31", out_level, 1);
        at(51); check("t4a_busy51", busy, 0);
        at(55);

        // trig in final GAP cycle, saturated queue
        do_reset();
        expect_pulse(11, 12); expect_pulse(31, 12); expect_pulse(51, 12);
        expect_pulse(71, 12); expect_pulse(91, 12);
        trig_at(10); trig_at(13); trig_at(14); trig_at(15);
        at(30); check("t4b_pend30", pend_cnt, 3);
        trig_at(30);
        at(31); check("t4b_pend31", pend_cnt, 3); check("t4b_drop31", drop, 0);
        at(51); check("t4b_pend51", pend_cnt, 2);
        at(91); check("t4b_pend91", pend_cnt, 0);
        at(110); check("t4b_busy110", busy, 1);
        at(111); check("t4b_busy111", busy, 0);
        at(115);

        // reset mid-ON with trig held during reset
        do_reset();
        expect_pulse(11, 5); expect_pulse(51, 12);
        trig_at(10); trig_at(12); trig_at(13);
        at(14); check("t5_pend14", pend_cnt, 2);
        at(15);
        reset = 1'b1;
        trig = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        trig = 1'b0;
        check("t5_out16", out_level, 0);
        check("t5_busy16", busy, 0);
        check("t5_pend16", pend_cnt, 0);
        at(40); check("t5_busy40", busy, 0);
        trig_at(50);
        at(51); check("t5_out51", out_level, 1);
        at(71); check("t5_busy71", busy, 0);
        at(80);

        check("pulses_left", exp_start.size(), 0);
        check("drops_left", exp_drop.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
